trap_ctrl: RTL and testbench
============================

# trap_ctrl

Trap controller that sits directly upstream of `csr`. It watches the commit stage for synchronous exceptions, `mret` and the machine timer interrupt. It sequences one trap at a time into `csr` through `exception_flag`, `exception_cause` and `epc`, then stalls and flushes the pipeline. Finally it redirects fetch to the trap target or to `mepc` and holds the redirect until fetch accepts it.

## Interface
Parameters:
- `XLEN`, 64: PC and data width. Must equal `MXLEN`.

Ports:
- `clk`  in  1  core clock.
- `rst`  in  1  reset, synchronous, active-low.
- `commit_valid`  in  1  an instruction is at commit this cycle.
- `commit_pc`  in  64  PC of the committing instruction.
- `commit_npc`  in  64  sequential next PC of the committing instruction.
- `commit_illegal`, `commit_ebreak`, `commit_ecall`, `commit_mret`  in  1 each  trap class of the committing instruction.
- `timer_irq`  in  1  level machine-timer interrupt from the CLINT.
- `mstatus_mie`  in  1  `mstatus[3]` from `csr`.
- `mie_mtie`  in  1  timer interrupt enable.
- `exception_target_pc`  in  64  from `csr`.
- `csr_mepc`  in  64  from `csr` (`diff_mepc`).
- `redirect_ready`  in  1  fetch accepts the redirect.
- `exception_flag`  out  1  one-cycle trap pulse to `csr`.
- `exception_cause`  out  5  `{interrupt, code[3:0]}` to `csr`.
- `epc`  out  64  to `csr`.
- `commit_kill`  out  1  suppress register/memory writeback of the committing instruction (combinational).
- `pipe_stall`  out  1  freeze all stages.
- `pipe_flush`  out  1  invalidate all stages.
- `redirect_valid`  out  1.
- `redirect_pc`  out  64.
- `diff_intr`  out  1  difftest interrupt-taken pulse.

## Operation
- FSM states: IDLE, TRAP, REDIRECT. Reset forces IDLE.
- Reset value of every registered output is 0.
- IDLE evaluates only when `commit_valid`=1. Priority:
  - illegal → cause 5'h02, epc=`commit_pc`, kill.
  - ebreak → 5'h03, epc=`commit_pc`, kill.
  - ecall → 5'h0B, epc=`commit_pc`, kill.
  - mret → `MRET` (5'h0F), epc unchanged.
  - interrupt (`timer_irq & mstatus_mie & mie_mtie`) → 5'h17, epc=`commit_npc`. The instruction retires and no kill is asserted.
- A synchronous exception always beats a pending interrupt. The interrupt stays pending; the trap clears MIE, so it is taken after `mret` re-enables interrupts.
- On any hit: capture cause and epc, then go IDLE→TRAP.
- TRAP (exactly 1 cycle):
  - `exception_flag`=1.
  - `pipe_stall`=1, `pipe_flush`=1.
  - `diff_intr`=1 if the cause is an interrupt.
  - Next state: REDIRECT.
- REDIRECT:
  - `redirect_valid`=1 and `pipe_stall`=1.
  - `redirect_pc` = `csr_mepc` if cause==`MRET`, else `exception_target_pc`. It is a combinational pass-through; `csr` state is stable because the pipeline is stalled.
  - Leave to IDLE on the cycle `redirect_valid & redirect_ready`.
- `commit_valid` is ignored outside IDLE.
- `exception_cause` and `epc` hold their last value after the trap.

## Timing
- Commit with trap at cycle T: `commit_kill` is asserted in T.
- T+1: `exception_flag` is high; `csr` updates on the T+1→T+2 edge.
- T+2: `redirect_valid`=1 with the post-update target. A redirect accepted in T+2 returns to IDLE in T+3. Minimum trap latency is 3 cycles.
- `redirect_ready` low holds REDIRECT indefinitely, with `redirect_pc` stable.
- `timer_irq` deasserting during TRAP/REDIRECT has no effect on a trap already taken.
- `rst` low in any state: next cycle is IDLE with all outputs 0. A trap in flight is dropped.

## Configuration
- `TRAP_CNT_EN` defined:
  - Adds outputs `trap_cnt` (64) and `intr_cnt` (64), both reset to 0.
  - Each increments by 1 in the TRAP cycle (`intr_cnt` only for interrupt causes; `MRET` is not counted). They wrap at 2^64.
- `TRAP_CNT_EN` undefined: neither the ports nor the counters exist; behaviour is otherwise identical.

## Structure
- Cause codes `CAUSE_ILLEGAL`, `CAUSE_BREAK`, `CAUSE_ECALL_M`, `CAUSE_MTIMER` and `MRET`, plus the FSM state encodings, go in `defines.v`, shared with `csr`.
- Sub-module `trap_prio`: the combinational priority encoder producing the hit, cause, epc select and kill.

## Test plan
- ecall at `commit_pc`=0x8000_0010, mtvec=0x8000_1000 → `exception_flag` at T+1 with cause 0x0B and epc 0x8000_0010; `redirect_pc`=0x8000_1000 at T+2; `commit_kill`=1 at T.
- mret with mepc=0x8000_0014 → cause 0x0F; `redirect_pc`=0x8000_0014; `commit_kill`=0.
- `timer_irq`=1, MIE=1, MTIE=1, commit at pc 0x100 with npc 0x104 → cause 0x17, epc 0x104, `diff_intr` pulse, no kill. Repeat with MIE=0 → no trap.
- illegal+ecall+irq in the same cycle → cause 0x02 only; irq is taken after a later `mret` restores MIE.
- `redirect_ready` held low 5 cycles → `redirect_valid` and `redirect_pc` stable; commits ignored; IDLE the cycle after ready.
- `rst` low during REDIRECT → IDLE, all outputs 0. With `TRAP_CNT_EN`, after 3 traps `trap_cnt`=3.

Source files
------------

// File: rtl/trap_ctrl_pkg.sv
// trap_ctrl_pkg: cause codes, FSM encodings and helpers shared by the trap
// controller and the csr block. Rev 1.0
`default_nettype none

package trap_ctrl_pkg;

  localparam logic [4:0] CAUSE_ILLEGAL = 5'h02;
  localparam logic [4:0] CAUSE_BREAK   = 5'h03;
  localparam logic [4:0] CAUSE_ECALL_M = 5'h0B;
  localparam logic [4:0] CAUSE_MTIMER  = 5'h17;
  localparam logic [4:0] MRET          = 5'h0F;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_TRAP     = 2'd1,
    ST_REDIRECT = 2'd2
  } state_t;

  typedef enum logic [1:0] {
    EPC_KEEP = 2'd0,
    EPC_PC   = 2'd1,
    EPC_NPC  = 2'd2
  } epc_sel_t;

  // Bit 4 of the cause is the interrupt flag.
  function automatic logic is_intr(input logic [4:0] cause);
    return cause[4];
  endfunction

endpackage

`default_nettype wire

// File: rtl/trap_ctrl_if.sv
// trap_ctrl_if: commit, csr and fetch-redirect signals of the trap controller.
// Optional counters under TRAP_CNT_EN. Rev 1.0
`default_nettype none

interface trap_ctrl_if #(parameter int XLEN = 64);
  logic            commit_valid;
  logic [XLEN-1:0] commit_pc;
  logic [XLEN-1:0] commit_npc;
  logic            commit_illegal;
  logic            commit_ebreak;
  logic            commit_ecall;
  logic            commit_mret;
  logic            timer_irq;
  logic            mstatus_mie;
  logic            mie_mtie;
  logic [XLEN-1:0] exception_target_pc;
  logic [XLEN-1:0] csr_mepc;
  logic            redirect_ready;
  logic            exception_flag;
  logic [4:0]      exception_cause;
  logic [XLEN-1:0] epc;
  logic            commit_kill;
  logic            pipe_stall;
  logic            pipe_flush;
  logic            redirect_valid;
  logic [XLEN-1:0] redirect_pc;
  logic            diff_intr;
`ifdef TRAP_CNT_EN
  logic [63:0]     trap_cnt;
  logic [63:0]     intr_cnt;
`endif

  modport master (
    input  commit_valid, commit_pc, commit_npc, commit_illegal, commit_ebreak,
           commit_ecall, commit_mret, timer_irq, mstatus_mie, mie_mtie,
           exception_target_pc, csr_mepc, redirect_ready,
    output exception_flag, exception_cause, epc, commit_kill, pipe_stall,
           pipe_flush, redirect_valid, redirect_pc, diff_intr
`ifdef TRAP_CNT_EN
    , output trap_cnt, intr_cnt
`endif
  );

  modport slave (
    output commit_valid, commit_pc, commit_npc, commit_illegal, commit_ebreak,
           commit_ecall, commit_mret, timer_irq, mstatus_mie, mie_mtie,
           exception_target_pc, csr_mepc, redirect_ready,
    input  exception_flag, exception_cause, epc, commit_kill, pipe_stall,
           pipe_flush, redirect_valid, redirect_pc, diff_intr
`ifdef TRAP_CNT_EN
    , input trap_cnt, intr_cnt
`endif
  );

endinterface

`default_nettype wire

// File: rtl/trap_prio.sv
// trap_prio: combinational priority encoder for commit-stage trap sources.
// Rev 1.0
`default_nettype none

module trap_prio
  import trap_ctrl_pkg::*;
(
  input  wire logic     i_valid,
  input  wire logic     i_illegal,
  input  wire logic     i_ebreak,
  input  wire logic     i_ecall,
  input  wire logic     i_mret,
  input  wire logic     i_irq,
  output      logic     o_hit,
  output      logic [4:0] o_cause,
  output      epc_sel_t o_epc_sel,
  output      logic     o_kill
);

  // Synchronous exceptions win over mret, which wins over the interrupt.
  always_comb begin
    o_hit     = 1'b0;
    o_cause   = 5'h00;
    o_epc_sel = EPC_KEEP;
    o_kill    = 1'b0;
    if (i_valid) begin
      if (i_illegal) begin
        o_hit = 1'b1; o_cause = CAUSE_ILLEGAL; o_epc_sel = EPC_PC; o_kill = 1'b1;
      end else if (i_ebreak) begin
        o_hit = 1'b1; o_cause = CAUSE_BREAK; o_epc_sel = EPC_PC; o_kill = 1'b1;
      end else if (i_ecall) begin
        o_hit = 1'b1; o_cause = CAUSE_ECALL_M; o_epc_sel = EPC_PC; o_kill = 1'b1;
      end else if (i_mret) begin
        o_hit = 1'b1; o_cause = MRET;
      end else if (i_irq) begin
        o_hit = 1'b1; o_cause = CAUSE_MTIMER; o_epc_sel = EPC_NPC;
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/trap_ctrl.sv
// trap_ctrl: sequences one trap at a time into csr, stalls/flushes, redirects
// fetch. Optional trap/interrupt counters under macro TRAP_CNT_EN. Rev 1.0
`default_nettype none

module trap_ctrl
  import trap_ctrl_pkg::*;
#(
  parameter int XLEN = 64
) (
  input wire logic   clk,
  input wire logic   rst,
  trap_ctrl_if.master bus
);

  state_t          r_state;
  state_t          w_next;
  logic [4:0]      r_cause;
  logic [XLEN-1:0] r_epc;
  logic            w_idle;
  logic            w_hit;
  logic [4:0]      w_cause;
  epc_sel_t        w_epc_sel;
  logic            w_kill;
  logic            w_irq;

  assign w_idle = (r_state == ST_IDLE);
  assign w_irq  = bus.timer_irq & bus.mstatus_mie & bus.mie_mtie;

  trap_prio u_prio (
    .i_valid   (bus.commit_valid & w_idle),
    .i_illegal (bus.commit_illegal),
    .i_ebreak  (bus.commit_ebreak),
    .i_ecall   (bus.commit_ecall),
    .i_mret    (bus.commit_mret),
    .i_irq     (w_irq),
    .o_hit     (w_hit),
    .o_cause   (w_cause),
    .o_epc_sel (w_epc_sel),
    .o_kill    (w_kill)
  );

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state <= ST_IDLE;
      r_cause <= 5'h00;
      r_epc   <= '0;
    end else begin
      r_state <= w_next;
      if (w_hit) begin
        r_cause <= w_cause;
        if (w_epc_sel == EPC_PC)
          r_epc <= bus.commit_pc;
        else if (w_epc_sel == EPC_NPC)
          r_epc <= bus.commit_npc;
      end
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE:     if (w_hit) w_next = ST_TRAP;
      ST_TRAP:     w_next = ST_REDIRECT;
      ST_REDIRECT: if (bus.redirect_ready) w_next = ST_IDLE;
      default:     w_next = ST_IDLE;
    endcase
  end

  assign bus.commit_kill     = w_kill;
  assign bus.exception_flag  = (r_state == ST_TRAP);
  assign bus.pipe_flush      = (r_state == ST_TRAP);
  assign bus.pipe_stall      = (r_state == ST_TRAP) || (r_state == ST_REDIRECT);
  assign bus.diff_intr       = (r_state == ST_TRAP) && is_intr(r_cause);
  assign bus.exception_cause = r_cause;
  assign bus.epc             = r_epc;
  assign bus.redirect_valid  = (r_state == ST_REDIRECT);
  // csr is frozen during REDIRECT, so passing its values straight through is safe.
  assign bus.redirect_pc     = (r_state != ST_REDIRECT) ? '0 :
                               (r_cause == MRET) ? bus.csr_mepc : bus.exception_target_pc;

`ifdef TRAP_CNT_EN
  logic [63:0] r_trap_cnt;
  logic [63:0] r_intr_cnt;

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_trap_cnt <= 64'd0;
      r_intr_cnt <= 64'd0;
    end else if ((r_state == ST_TRAP) && (r_cause != MRET)) begin
      r_trap_cnt <= r_trap_cnt + 64'd1;
      if (is_intr(r_cause))
        r_intr_cnt <= r_intr_cnt + 64'd1;
    end
  end

  assign bus.trap_cnt = r_trap_cnt;
  assign bus.intr_cnt = r_intr_cnt;
`endif

endmodule

`default_nettype wire

// File: tb/tb_trap_ctrl.sv
// tb_trap_ctrl: scoreboard bench for trap_ctrl with a tiny mstatus.MIE model.
// Rev 1.0
`default_nettype none

module tb_trap_ctrl;

  localparam logic [63:0] C_MTVEC = 64'h8000_1000;

  typedef struct {
    logic [4:0]  cause;
    logic [63:0] epc;
    logic        intr;
  } exp_t;

  logic        clk;
  logic        rst;
  logic        r_mie;
  logic        r_mpie;
  int          n_checks;
  int          n_errors;
  exp_t        q_exp[$];

  trap_ctrl_if #(.XLEN(64)) bus ();

  trap_ctrl #(.XLEN(64)) u_dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign bus.mstatus_mie = r_mie;

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s got %0h expected %0h", tag, act, exp);
    end
  endtask

  // csr model: a trap saves and clears MIE, mret restores it.
  always @(posedge clk) begin
    if (rst && bus.exception_flag) begin
      if (bus.exception_cause == 5'h0F) begin
        r_mie <= r_mpie;
      end else begin
        r_mpie <= r_mie;
        r_mie  <= 1'b0;
      end
    end
  end

  // Scoreboard consumer: every trap pulse must match the oldest expectation.
  always @(negedge clk) begin
    if (rst && bus.exception_flag) begin
      if (q_exp.size() == 0) begin
        check("unexpected_trap", 64'd1, 64'd0);
      end else begin
        exp_t e;
        e = q_exp.pop_front();
        check("cause", {59'd0, bus.exception_cause}, {59'd0, e.cause});
        check("epc", bus.epc, e.epc);
        check("diff_intr", {63'd0, bus.diff_intr}, {63'd0, e.intr});
        check("trap_stall_flush", {62'd0, bus.pipe_stall, bus.pipe_flush}, 64'd3);
      end
    end
  end

  task automatic clear_commit();
    bus.commit_valid   = 1'b0;
    bus.commit_illegal = 1'b0;
    bus.commit_ebreak  = 1'b0;
    bus.commit_ecall   = 1'b0;
    bus.commit_mret    = 1'b0;
  endtask

  // cls = {illegal, ebreak, ecall, mret}; hold = cycles redirect_ready stays low.
  task automatic commit_op(input logic [63:0] pc, input logic [63:0] npc,
                           input logic [3:0] cls, input bit exp_trap,
                           input logic [4:0] cause, input logic [63:0] eepc,
                           input bit kill, input logic [63:0] rpc, input int hold);
    exp_t e;
    @(posedge clk); #1;
    bus.commit_valid   = 1'b1;
    bus.commit_pc      = pc;
    bus.commit_npc     = npc;
    {bus.commit_illegal, bus.commit_ebreak, bus.commit_ecall, bus.commit_mret} = cls;
    if (exp_trap) begin
      e.cause = cause; e.epc = eepc; e.intr = cause[4];
      q_exp.push_back(e);
    end
    @(negedge clk);
    check("commit_kill", {63'd0, bus.commit_kill}, {63'd0, kill});
    @(posedge clk); #1;
    clear_commit();
    @(negedge clk);
    if (exp_trap) begin
      for (int i = 0; i <= hold; i++) begin
        @(negedge clk);
        check("redirect_valid", {63'd0, bus.redirect_valid}, 64'd1);
        check("redirect_pc", bus.redirect_pc, rpc);
        check("redirect_stall", {63'd0, bus.pipe_stall}, 64'd1);
        if (i > 0) check("ignored_commit", {63'd0, bus.exception_flag}, 64'd0);
        if (i < hold) begin
          bus.redirect_ready = 1'b0;
          bus.commit_valid   = 1'b1;
          bus.commit_illegal = 1'b1;
        end else begin
          clear_commit();
          bus.redirect_ready = 1'b1;
        end
      end
      @(negedge clk);
      check("back_to_idle", {62'd0, bus.redirect_valid, bus.pipe_stall}, 64'd0);
    end else begin
      check("no_trap", {63'd0, bus.exception_flag}, 64'd0);
    end
  endtask

  task automatic check_all_zero(input string tag);
    check(tag, {57'd0, bus.exception_flag, bus.commit_kill, bus.pipe_stall,
                bus.pipe_flush, bus.redirect_valid, bus.diff_intr, 1'b0}, 64'd0);
    check({tag, "_cause"}, {59'd0, bus.exception_cause}, 64'd0);
    check({tag, "_epc"}, bus.epc, 64'd0);
    check({tag, "_rpc"}, bus.redirect_pc, 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    n_checks = 0;
    n_errors = 0;
    rst    = 1'b0;
    r_mie  = 1'b1;
    r_mpie = 1'b0;
    clear_commit();
    bus.commit_pc           = '0;
    bus.commit_npc          = '0;
    bus.timer_irq           = 1'b0;
    bus.mie_mtie            = 1'b1;
    bus.exception_target_pc = C_MTVEC;
    bus.csr_mepc            = 64'h8000_0014;
    bus.redirect_ready      = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_all_zero("reset");
    @(posedge clk); #1;
    rst = 1'b1;

    // ecall
    commit_op(64'h8000_0010, 64'h8000_0014, 4'b0010, 1, 5'h0B, 64'h8000_0010, 1, C_MTVEC, 0);
    // mret: epc unchanged, redirect to mepc, MIE restored
    commit_op(64'h8000_1000, 64'h8000_1004, 4'b0001, 1, 5'h0F, 64'h8000_0010, 0, 64'h8000_0014, 0);
    // timer interrupt on a plain commit
    bus.timer_irq = 1'b1;
    commit_op(64'h100, 64'h104, 4'b0000, 1, 5'h17, 64'h104, 0, C_MTVEC, 0);
    // MIE now cleared: pending interrupt must not be taken
    commit_op(64'h108, 64'h10C, 4'b0000, 0, 5'h00, 64'h0, 0, 64'h0, 0);
    bus.csr_mepc = 64'h104;
    commit_op(64'h8000_1000, 64'h8000_1004, 4'b0001, 1, 5'h0F, 64'h104, 0, 64'h104, 0);
    // illegal + ecall + irq together: illegal wins
    commit_op(64'h200, 64'h204, 4'b1010, 1, 5'h02, 64'h200, 1, C_MTVEC, 0);
    commit_op(64'h204, 64'h208, 4'b0000, 0, 5'h00, 64'h0, 0, 64'h0, 0);
    // mret re-enables MIE, then the still-pending interrupt is taken
    bus.csr_mepc = 64'h208;
    commit_op(64'h8000_1000, 64'h8000_1004, 4'b0001, 1, 5'h0F, 64'h200, 0, 64'h208, 0);
    commit_op(64'h208, 64'h20C, 4'b0000, 1, 5'h17, 64'h20C, 0, C_MTVEC, 0);
    bus.timer_irq = 1'b0;
    // ebreak with fetch back-pressure for 5 cycles, commits ignored meanwhile
    commit_op(64'h300, 64'h304, 4'b0100, 1, 5'h03, 64'h300, 1, C_MTVEC, 5);

`ifdef TRAP_CNT_EN
    check("trap_cnt", bus.trap_cnt, 64'd5);
    check("intr_cnt", bus.intr_cnt, 64'd2);
`endif

    // reset while in REDIRECT drops the trap
    @(posedge clk); #1;
    bus.redirect_ready = 1'b0;
    bus.commit_valid   = 1'b1;
    bus.commit_pc      = 64'h400;
    bus.commit_npc     = 64'h404;
    bus.commit_ecall   = 1'b1;
    begin
      exp_t e;
      e.cause = 5'h0B; e.epc = 64'h400; e.intr = 1'b0;
      q_exp.push_back(e);
    end
    @(posedge clk); #1;
    clear_commit();
    @(posedge clk); #1;
    @(negedge clk);
    check("pre_reset_redirect", {63'd0, bus.redirect_valid}, 64'd1);
    rst = 1'b0;
    @(negedge clk);
    check_all_zero("reset_in_redirect");
`ifdef TRAP_CNT_EN
    check("trap_cnt_rst", bus.trap_cnt, 64'd0);
    check("intr_cnt_rst", bus.intr_cnt, 64'd0);
`endif
    rst = 1'b1;
    bus.redirect_ready = 1'b1;
    repeat (2) @(negedge clk);
    check("idle_after_reset", {62'd0, bus.redirect_valid, bus.exception_flag}, 64'd0);
    check("scoreboard_empty", 64'(q_exp.size()), 64'd0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

`default_nettype wire
